// File: rtl/cla_sum_accumulator.sv
// Frame accumulator fed by a 3-bit carry-lookahead pair adder.
// Sums COUNT accepted operand pairs and presents the total over valid/ready.
module cla_sum_accumulator #(
    parameter int unsigned ACC_W = 8,
    parameter int unsigned COUNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       a,
    input  logic [2:0]       b,
    input  logic             cin,
    output logic [3:0]       last_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf,
    output logic             busy
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned EXT_W = ACC_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(COUNT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [ACC_W-1:0]   acc, acc_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               ovf, ovf_n;
    logic [3:0]         last_n;
    logic               in_ready_n, busy_n, out_valid_n;
    logic               accept;
    logic [EXT_W-1:0]   acc_ext;

    logic [2:0]         gen, prop;
    logic [3:0]         carry;
    logic [3:0]         pair_sum;

    // Carry-lookahead pair adder: every carry is formed directly from g/p and cin
    always_comb begin
        gen      = a & b;
        prop     = a ^ b;
        carry[0] = cin;
        carry[1] = gen[0] | (prop[0] & cin);
        carry[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & cin);
        carry[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
                 | (prop[2] & prop[1] & prop[0] & cin);
        pair_sum = {carry[3], prop ^ carry[2:0]};
    end

    assign accept = in_valid & in_ready;

    // Next-state and datapath update; clr overrides everything including the output handshake
    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        ovf_n   = ovf;
        last_n  = last_sum;
        acc_ext = '0;

        if (clr) begin
            state_n = IDLE;
            acc_n   = '0;
            cnt_n   = '0;
            ovf_n   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc_ext = EXT_W'(pair_sum);
                        acc_n   = acc_ext[ACC_W-1:0];
                        ovf_n   = acc_ext[ACC_W];
                        cnt_n   = CNT_W'(1);
                        last_n  = pair_sum;
                        state_n = (COUNT == 1) ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc_ext = {1'b0, acc} + EXT_W'(pair_sum);
                        acc_n   = acc_ext[ACC_W-1:0];
                        ovf_n   = ovf | acc_ext[ACC_W];
                        cnt_n   = cnt + CNT_W'(1);
                        last_n  = pair_sum;
                        if (cnt == LAST_IDX) begin
                            state_n = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_n = IDLE;
                        acc_n   = '0;
                        cnt_n   = '0;
                        ovf_n   = 1'b0;
                    end
                end
                default: begin
                    state_n = IDLE;
                    acc_n   = '0;
                    cnt_n   = '0;
                    ovf_n   = 1'b0;
                end
            endcase
        end

        in_ready_n  = (state_n != HOLD);
        busy_n      = (state_n != IDLE);
        out_valid_n = (state_n == HOLD);
    end

    // Handshake flags are registered alongside the state they decode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            last_sum  <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            acc       <= acc_n;
            cnt       <= cnt_n;
            ovf       <= ovf_n;
            last_sum  <= last_n;
            in_ready  <= in_ready_n;
            busy      <= busy_n;
            out_valid <= out_valid_n;
        end
    end

    assign out_sum = acc;
    assign out_ovf = ovf;

endmodule

// File: doc/cla_sum_accumulator.md
Name: cla_sum_accumulator

Overview:
- Sequential consumer that sits directly downstream of the 3-bit carry-lookahead adder stage.
- Accepts 3-bit operand pairs plus carry-in over a valid/ready handshake and forms each 4-bit sum (A+B+Cin, range 0..15) internally.
- Accumulates COUNT consecutive sums into a frame total and presents the total over an output valid/ready handshake.
- Provides a registered copy of the most recent 4-bit sum for observation.

Parameters:
- ACC_W, 8, width of the accumulator and out_sum in bits (legal range 4..16).
- COUNT, 4, number of accepted operand pairs per frame (legal range 1..255).

Ports:
- clk  input  1  single rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous frame abort; discards the partial frame.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair this cycle.
- a  input  3  operand A.
- b  input  3  operand B.
- cin  input  1  carry-in for this pair.
- last_sum  output  4  registered sum of the last accepted pair.
- out_valid  output  1  frame total is valid.
- out_ready  input  1  consumer accepts the frame total.
- out_sum  output  ACC_W  frame total, modulo 2^ACC_W.
- out_ovf  output  1  frame total exceeded 2^ACC_W-1 (sticky within the frame).
- busy  output  1  a frame is in progress (state ACCUM or HOLD).

Behaviour:
- Reset (rst=1, asynchronous): state=IDLE, acc=0, cnt=0, ovf=0, last_sum=0, out_valid=0, busy=0. in_ready=1 once rst deasserts.
- An input is accepted when in_valid=1 and in_ready=1 at a clk edge.
- Per accepted pair: s = a+b+cin, zero-extended to 5 bits, truncated to 4 bits (maximum 15, so no loss).
  - last_sum <= s.
  - {carry, acc} <= acc + s, computed at ACC_W+1 bits.
  - acc keeps the low ACC_W bits. ovf <= ovf | carry.
  - cnt <= cnt+1.
- States:
  - IDLE: in_ready=1, busy=0. On accept, apply the update to acc=0 and ovf=0 (the new frame starts from the accepted pair). Go to ACCUM, or to HOLD if COUNT=1.
  - ACCUM: in_ready=1, busy=1. On accept with cnt==COUNT-1, go to HOLD. Otherwise remain in ACCUM.
  - HOLD: in_ready=0, out_valid=1, busy=1. out_sum=acc and out_ovf=ovf are held stable until the handshake. On out_valid&out_ready, go to IDLE and clear acc, cnt and ovf.
- Latency: out_valid rises on the clk edge that accepts the COUNT-th pair, and is visible in the following cycle.
- In the HOLD handshake cycle, in_ready is still 0. A pending in_valid is accepted no earlier than the next cycle, which is in IDLE.
- Back-to-back throughput: COUNT accept cycles plus at least 1 HOLD cycle per frame.
- out_sum and out_ovf are only meaningful while out_valid=1. Outside HOLD they show the running acc and ovf.
- clr=1 (synchronous, any state): next state IDLE; acc, cnt, ovf and out_valid are cleared. last_sum is unchanged.
  - An input presented in the same cycle as clr is not accumulated, even if in_ready=1.
  - clr has priority over the output handshake.
- rst asserted mid-frame: immediate return to reset values, no partial output.
- in_valid=0 in ACCUM: hold all state, with no timeout.
- X/garbage on a, b and cin is ignored when in_valid=0.

Test Plan:
- Reset then frame (ACC_W=8, COUNT=4): pairs (7,7,1),(3,2,0),(0,0,1),(5,6,0), out_ready=1.
  - Expected: last_sum sequence 15,5,1,11.
  - Expected: out_valid high one cycle after the 4th accept with out_sum=32, out_ovf=0, then return to IDLE.
- Overflow (ACC_W=6, COUNT=5): five pairs (7,7,1).
  - Expected: out_sum=11 (75 mod 64), out_ovf=1.
  - Expected: the next frame of five (0,0,0) gives out_sum=0, out_ovf=0.
- Backpressure: complete a frame, hold out_ready=0 for 6 cycles with in_valid=1.
  - Expected: in_ready=0 throughout; out_sum stable; no accepts.
  - Expected: out_ready=1 pulse yields IDLE, then the pending pair is accepted the next cycle.
- Abort: after 2 accepted pairs (sum 20), pulse clr together with in_valid=1 (a=1,b=1,cin=0).
  - Expected: state IDLE, acc=0, that pair not counted.
  - Expected: the next 4 pairs (1,1,0) give out_sum=8.
- Async reset mid-frame: assert rst between clk edges after 3 accepts.
  - Expected: out_valid=0, busy=0, last_sum=0 immediately without a clock.
  - Expected: after release, a fresh frame of 4×(2,3,0) gives out_sum=20.
- COUNT=1 edge case with a stall: in_valid toggling 1,0,0,1 with pair (4,4,1).
  - Expected: each accept goes straight to HOLD with out_sum=9.
  - Expected: idle cycles leave state unchanged.
